// File: rtl/risc_pkg.sv
// risc_pkg: shared definitions for the multi-cycle RISC core.
//   - instruction field bit positions
//   - opcode and ALU funct encodings
//   - FSM state encoding
package risc_pkg;

  // Instruction word layout (16 bits)
  localparam int OP_LSB    = 13;
  localparam int RD_LSB    = 11;
  localparam int RS1_LSB   = 9;
  localparam int RS2_LSB   = 7;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;
  localparam int IMM_W     = 8;

  // Opcodes
  localparam logic [2:0] OP_ALU   = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_JUMP  = 3'b100;
  localparam logic [2:0] OP_BEQZ  = 3'b101;
  localparam logic [2:0] OP_LI    = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  // ALU funct codes
  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;
  localparam logic [2:0] F_AND = 3'b010;
  localparam logic [2:0] F_OR  = 3'b011;
  localparam logic [2:0] F_XOR = 3'b100;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_IO_RD,
    S_IO_WR,
    S_HALT
  } state_t;

endpackage

// File: rtl/risc_alu.sv
// risc_alu: combinational ALU, funct-selected, modulo 2^DATA_W.
//   a_i, b_i  : operands
//   funct_i   : operation select
//   y_o       : result
//   ok_o      : 1 when funct_i is a defined operation (else the op is a NOP)
module risc_alu
  import risc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [2:0]        funct_i,
  output logic [DATA_W-1:0] y_o,
  output logic              ok_o
);

  always_comb begin
    y_o  = '0;
    ok_o = 1'b1;
    case (funct_i)
      F_ADD:   y_o = a_i + b_i;
      F_SUB:   y_o = a_i - b_i;
      F_AND:   y_o = a_i & b_i;
      F_OR:    y_o = a_i | b_i;
      F_XOR:   y_o = a_i ^ b_i;
      default: ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/risc_core_mc.sv
// risc_core_mc: multi-cycle 4-register RISC core with FETCH/DECODE/EXEC/
// MEM/WB/IO_RD/IO_WR/HALT sequencing.
//   clk, reset           : rising-edge clock, synchronous active-low reset
//   imem_addr/imem_data  : instruction ROM (data one cycle after address)
//   dmem_*               : data RAM (read data one cycle after address)
//   io_rd_*              : input port handshake (core drives ready)
//   io_wr_*              : output port handshake (core drives valid/data)
//   pc, halted           : current PC and HALT status
module risc_core_mc
  import risc_pkg::*;
#(
  parameter int                DATA_W  = 8,
  parameter int                ADDR_W  = 8,
  parameter logic [ADDR_W-1:0] IO_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              io_rd_ready,
  input  logic              io_rd_valid,
  input  logic [DATA_W-1:0] io_rd_data,
  output logic              io_wr_valid,
  input  logic              io_wr_ready,
  output logic [DATA_W-1:0] io_wr_data,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [2:0]          op_q;
  logic [1:0]          rd_q;
  logic [2:0]          funct_q;
  logic [IMM_W-1:0]    imm_q;
  logic [DATA_W-1:0]   a_q, b_q, c_q;   // rs1, rs2, rd operand values
  logic [DATA_W-1:0]   res_q;
  logic                wen_q;
  logic [DATA_W-1:0]   rf_q [4];
  logic [ADDR_W-1:0]   dmem_addr_q;
  logic                dmem_we_q;
  logic [DATA_W-1:0]   dmem_wdata_q;
  logic                io_rd_ready_q;
  logic                io_wr_valid_q;
  logic [DATA_W-1:0]   io_wr_data_q;
  logic                halted_q;

  logic [DATA_W-1:0]   imm_d;
  logic [ADDR_W-1:0]   imm_a;
  logic [ADDR_W-1:0]   ea;
  logic [ADDR_W-1:0]   pc_inc;
  logic [DATA_W-1:0]   alu_b;
  logic [2:0]          alu_f;
  logic [DATA_W-1:0]   alu_y;
  logic                alu_ok;

  // R0 is hard-wired to zero on every read path.
  function automatic logic [DATA_W-1:0] rf_rd(input logic [1:0] idx);
    return (idx == 2'd0) ? '0 : rf_q[idx];
  endfunction

  assign imm_d  = DATA_W'(imm_q);
  assign imm_a  = ADDR_W'(imm_q);
  assign ea     = ADDR_W'(a_q) + imm_a;
  assign pc_inc = pc_q + ADDR_W'(1);

  // ADDI reuses the adder with the immediate as second operand.
  assign alu_b = (op_q == OP_ADDI) ? imm_d : b_q;
  assign alu_f = (op_q == OP_ADDI) ? F_ADD : funct_q;

  risc_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i     (a_q),
    .b_i     (alu_b),
    .funct_i (alu_f),
    .y_o     (alu_y),
    .ok_o    (alu_ok)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_FETCH;
      pc_q          <= '0;
      op_q          <= OP_ALU;
      rd_q          <= '0;
      funct_q       <= '0;
      imm_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      res_q         <= '0;
      wen_q         <= 1'b0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      dmem_addr_q   <= '0;
      dmem_we_q     <= 1'b0;
      dmem_wdata_q  <= '0;
      io_rd_ready_q <= 1'b0;
      io_wr_valid_q <= 1'b0;
      io_wr_data_q  <= '0;
      halted_q      <= 1'b0;
    end else begin
      dmem_we_q <= 1'b0;
      case (state_q)
        S_FETCH: state_q <= S_DECODE;

        S_DECODE: begin
          op_q    <= imem_data[OP_LSB +: 3];
          rd_q    <= imem_data[RD_LSB +: 2];
          funct_q <= imem_data[FUNCT_LSB +: 3];
          imm_q   <= imem_data[IMM_LSB +: IMM_W];
          a_q     <= rf_rd(imem_data[RS1_LSB +: 2]);
          b_q     <= rf_rd(imem_data[RS2_LSB +: 2]);
          c_q     <= rf_rd(imem_data[RD_LSB +: 2]);
          if (imem_data[OP_LSB +: 3] == OP_HALT) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end

        S_EXEC: begin
          case (op_q)
            OP_ALU, OP_ADDI: begin
              res_q   <= alu_y;
              wen_q   <= alu_ok;
              state_q <= S_WB;
            end
            OP_LI: begin
              res_q   <= imm_d;
              wen_q   <= 1'b1;
              state_q <= S_WB;
            end
            OP_JUMP: begin
              pc_q    <= imm_a;
              state_q <= S_FETCH;
            end
            OP_BEQZ: begin
              pc_q    <= (c_q == '0) ? imm_a : pc_inc;
              state_q <= S_FETCH;
            end
            OP_LOAD: begin
              if (ea == IO_ADDR) begin
                io_rd_ready_q <= 1'b1;
                state_q       <= S_IO_RD;
              end else begin
                dmem_addr_q <= ea;
                wen_q       <= 1'b1;
                state_q     <= S_MEM;
              end
            end
            OP_STORE: begin
              // The I/O address never reaches the RAM port.
              if (ea == IO_ADDR) begin
                io_wr_valid_q <= 1'b1;
                io_wr_data_q  <= c_q;
                state_q       <= S_IO_WR;
              end else begin
                dmem_addr_q  <= ea;
                dmem_wdata_q <= c_q;
                dmem_we_q    <= 1'b1;
                state_q      <= S_MEM;
              end
            end
            default: begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
          endcase
        end

        // Store: RAM writes on this edge. Load: RAM samples the address here.
        S_MEM: begin
          if (op_q == OP_STORE) begin
            pc_q    <= pc_inc;
            state_q <= S_FETCH;
          end else begin
            state_q <= S_WB;
          end
        end

        S_WB: begin
          if (wen_q && rd_q != 2'd0)
            rf_q[rd_q] <= (op_q == OP_LOAD) ? dmem_rdata : res_q;
          wen_q   <= 1'b0;
          pc_q    <= pc_inc;
          state_q <= S_FETCH;
        end

        S_IO_RD: begin
          if (io_rd_valid) begin
            io_rd_ready_q <= 1'b0;
            if (rd_q != 2'd0) rf_q[rd_q] <= io_rd_data;
            pc_q    <= pc_inc;
            state_q <= S_FETCH;
          end
        end

        S_IO_WR: begin
          if (io_wr_ready) begin
            io_wr_valid_q <= 1'b0;
            pc_q          <= pc_inc;
            state_q       <= S_FETCH;
          end
        end

        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign io_rd_ready = io_rd_ready_q;
  assign io_wr_valid = io_wr_valid_q;
  assign io_wr_data  = io_wr_data_q;

endmodule

// File: tb/tb_risc_core_mc.sv
// tb_risc_core_mc: self-checking bench for risc_core_mc. Runs an 8-bit and a
// 16-bit instance in lockstep on a shared instruction ROM with separate RAMs.
module tb_risc_core_mc;

  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  imem_addr8, imem_addr16, dmem_addr8, dmem_addr16, pc8, pc16;
  logic [15:0] imem_data8, imem_data16;
  logic        dmem_we8, dmem_we16, halted8, halted16;
  logic [7:0]  dmem_wdata8, dmem_rdata8, io_wr_data8;
  logic [15:0] dmem_wdata16, dmem_rdata16, io_wr_data16;
  logic        io_rd_ready8, io_rd_ready16, io_wr_valid8, io_wr_valid16;
  logic        io_rd_valid = 1'b0;
  logic [7:0]  io_rd_data = 8'h00;
  logic        io_wr_ready = 1'b0;

  risc_core_mc #(.DATA_W(8), .ADDR_W(8)) dut8 (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr8), .imem_data(imem_data8),
    .dmem_addr(dmem_addr8), .dmem_we(dmem_we8), .dmem_wdata(dmem_wdata8), .dmem_rdata(dmem_rdata8),
    .io_rd_ready(io_rd_ready8), .io_rd_valid(io_rd_valid), .io_rd_data(io_rd_data),
    .io_wr_valid(io_wr_valid8), .io_wr_ready(io_wr_ready), .io_wr_data(io_wr_data8),
    .pc(pc8), .halted(halted8)
  );

  risc_core_mc #(.DATA_W(16), .ADDR_W(8)) dut16 (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr16), .imem_data(imem_data16),
    .dmem_addr(dmem_addr16), .dmem_we(dmem_we16), .dmem_wdata(dmem_wdata16), .dmem_rdata(dmem_rdata16),
    .io_rd_ready(io_rd_ready16), .io_rd_valid(io_rd_valid), .io_rd_data({8'h00, io_rd_data}),
    .io_wr_valid(io_wr_valid16), .io_wr_ready(io_wr_ready), .io_wr_data(io_wr_data16),
    .pc(pc16), .halted(halted16)
  );

  // Memories: synchronous-read ROM/RAM, plus bench-side clear/preset port.
  logic [15:0] rom  [256];
  logic [7:0]  ram8 [256];
  logic [15:0] ram16[256];
  logic        clr, pre_we;
  logic [7:0]  pre_addr, pre_d8;
  logic [15:0] pre_d16;

  always @(posedge clk) begin
    imem_data8   <= rom[imem_addr8];
    imem_data16  <= rom[imem_addr16];
    dmem_rdata8  <= ram8[dmem_addr8];
    dmem_rdata16 <= ram16[dmem_addr16];
    if (clr) begin
      for (int i = 0; i < 256; i++) begin
        ram8[i]  <= 8'h00;
        ram16[i] <= 16'h0000;
      end
    end else begin
      if (pre_we) begin
        ram8[pre_addr]  <= pre_d8;
        ram16[pre_addr] <= pre_d16;
      end
      if (dmem_we8)  ram8[dmem_addr8]   <= dmem_wdata8;
      if (dmem_we16) ram16[dmem_addr16] <= dmem_wdata16;
    end
  end

  // I/O responders and observers (cumulative counters, sampled mid-cycle).
  logic wr_block;
  int   rd_cnt = 0, wr_cnt = 0;
  int   we_total = 0, rd_rdy_total = 0, wr_acc_cnt = 0, wr_unstable = 0, lock_err = 0;
  logic       wr_in = 1'b0;
  logic [7:0] wr_hold = 8'h00, wr_acc_data = 8'h00;
  logic       wr_rdy_nxt;
  assign wr_rdy_nxt = !wr_block && (wr_cnt == 2);

  always @(negedge clk) begin
    if (dmem_we8) we_total <= we_total + 1;
    if (io_rd_ready8) begin
      rd_rdy_total <= rd_rdy_total + 1;
      io_rd_valid  <= (rd_cnt == 3);
      io_rd_data   <= 8'hF0;
      rd_cnt       <= rd_cnt + 1;
    end else begin
      io_rd_valid <= 1'b0;
      rd_cnt      <= 0;
    end
    if (io_wr_valid8) begin
      io_wr_ready <= wr_rdy_nxt;
      wr_cnt      <= wr_cnt + 1;
      if (wr_in && io_wr_data8 != wr_hold) wr_unstable <= wr_unstable + 1;
      wr_hold <= io_wr_data8;
      wr_in   <= 1'b1;
      if (wr_rdy_nxt) begin
        wr_acc_cnt  <= wr_acc_cnt + 1;
        wr_acc_data <= io_wr_data8;
      end
    end else begin
      io_wr_ready <= 1'b0;
      wr_cnt      <= 0;
      wr_in       <= 1'b0;
    end
    if (io_rd_ready16 != io_rd_ready8 || io_wr_valid16 != io_wr_valid8) lock_err <= lock_err + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] rtype(input logic [1:0] rd, input logic [1:0] rs1,
                                        input logic [1:0] rs2, input logic [2:0] f);
    return {3'b000, rd, rs1, rs2, 4'b0000, f};
  endfunction

  function automatic logic [15:0] itype(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [7:0] imm);
    return {op, rd, rs1, 1'b0, imm};
  endfunction

  function automatic logic [15:0] li(input logic [1:0] rd, input logic [7:0] imm);
    return itype(3'b110, rd, 2'd0, imm);
  endfunction

  function automatic logic [15:0] st(input logic [1:0] rd, input logic [1:0] rs1, input logic [7:0] imm);
    return itype(3'b011, rd, rs1, imm);
  endfunction

  task automatic begin_test();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 256; i++) rom[i] = 16'hE000;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic ram_set(input logic [7:0] a, input logic [7:0] d8, input logic [15:0] d16);
    @(negedge clk);
    pre_addr = a; pre_d8 = d8; pre_d16 = d16; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Release reset, check the reset state, then count edges until HALT.
  task automatic run_prog(input int exp_cyc, input logic [7:0] exp_pc, input string nm);
    int cyc;
    cyc = 0;
    @(negedge clk);
    reset = 1'b1;
    chk({nm, "_rst_imem_addr"}, imem_addr8, 8'h00);
    chk({nm, "_rst_halted"}, halted8, 1'b0);
    while (halted8 !== 1'b1 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_cycles"}, cyc, exp_cyc);
    chk({nm, "_pc8"}, pc8, exp_pc);
    chk({nm, "_pc16"}, pc16, exp_pc);
    chk({nm, "_halted16"}, halted16, 1'b1);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  f;
    logic [7:0]  e8;
    logic [15:0] e16;
  } vec_t;

  vec_t vecs[9];
  int   we0, rd0, wa0, wu0;
  logic seen;

  initial begin
    reset = 1'b0; clr = 1'b0; pre_we = 1'b0; wr_block = 1'b0;
    pre_addr = 8'h00; pre_d8 = 8'h00; pre_d16 = 16'h0000;
    for (int i = 0; i < 256; i++) rom[i] = 16'hE000;

    vecs[0] = '{8'h0F, 8'h01, 3'd0, 8'h10, 16'h0010};
    vecs[1] = '{8'hF0, 8'h20, 3'd0, 8'h10, 16'h0110};
    vecs[2] = '{8'hF0, 8'hA5, 3'd1, 8'h4B, 16'h004B};
    vecs[3] = '{8'h05, 8'h0A, 3'd1, 8'hFB, 16'hFFFB};
    vecs[4] = '{8'hF0, 8'h3C, 3'd2, 8'h30, 16'h0030};
    vecs[5] = '{8'hF0, 8'h0F, 3'd3, 8'hFF, 16'h00FF};
    vecs[6] = '{8'hAA, 8'hFF, 3'd4, 8'h55, 16'h0055};
    vecs[7] = '{8'h12, 8'h34, 3'd5, 8'h77, 16'h0077};
    vecs[8] = '{8'h12, 8'h34, 3'd7, 8'h77, 16'h0077};

    // ALU table: LI R1,a; LI R2,b; LI R3,77; ALU R3,R1,R2; STORE R3,0x30(R0); HALT
    for (int i = 0; i < 9; i++) begin
      begin_test();
      rom[0] = li(2'd1, vecs[i].a);
      rom[1] = li(2'd2, vecs[i].b);
      rom[2] = li(2'd3, 8'h77);
      rom[3] = rtype(2'd3, 2'd1, 2'd2, vecs[i].f);
      rom[4] = st(2'd3, 2'd0, 8'h30);
      run_prog(22, 8'h05, $sformatf("alu%0d", i));
      chk($sformatf("alu%0d_ram8", i), ram8[8'h30], vecs[i].e8);
      chk($sformatf("alu%0d_ram16", i), ram16[8'h30], vecs[i].e16);
    end

    // R0 stays zero; HALT freezes the PC.
    begin_test();
    rom[0] = li(2'd0, 8'h55);
    rom[1] = li(2'd1, 8'h0F);
    rom[2] = rtype(2'd2, 2'd1, 2'd0, 3'd0);
    rom[3] = st(2'd2, 2'd0, 8'h20);
    rom[4] = st(2'd0, 2'd0, 8'h21);
    ram_set(8'h21, 8'hEE, 16'hEEEE);
    run_prog(22, 8'h05, "r0");
    chk("r0_ram20", ram8[8'h20], 8'h0F);
    chk("r0_ram21", ram8[8'h21], 8'h00);
    chk("r0_ram16_20", ram16[8'h20], 16'h000F);
    chk("r0_ram16_21", ram16[8'h21], 16'h0000);
    repeat (5) @(posedge clk);
    #1;
    chk("halt_pc_frozen", pc8, 8'h05);
    chk("halt_stays", halted8, 1'b1);

    // Load/store through RAM with a base register.
    begin_test();
    rom[0] = li(2'd3, 8'h08);
    rom[1] = itype(3'b010, 2'd1, 2'd3, 8'h08);
    rom[2] = rtype(2'd2, 2'd1, 2'd0, 3'd0);
    rom[3] = st(2'd2, 2'd3, 8'h18);
    ram_set(8'h10, 8'hA5, 16'hBEEF);
    we0 = we_total;
    run_prog(19, 8'h04, "ldst");
    chk("ldst_ram20", ram8[8'h20], 8'hA5);
    chk("ldst_ram16_20", ram16[8'h20], 16'hBEEF);
    chk("ldst_we_cycles", we_total - we0, 1);

    // Subtract / ADDI wrap.
    begin_test();
    rom[0] = li(2'd1, 8'hF0);
    rom[1] = li(2'd2, 8'hA5);
    rom[2] = rtype(2'd3, 2'd1, 2'd2, 3'd1);
    rom[3] = itype(3'b001, 2'd3, 2'd3, 8'hC0);
    rom[4] = st(2'd3, 2'd0, 8'h30);
    run_prog(22, 8'h05, "wrap");
    chk("wrap_ram8", ram8[8'h30], 8'h0B);
    chk("wrap_ram16", ram16[8'h30], 16'h010B);

    // JUMP, BEQZ taken and not taken.
    begin_test();
    rom[8'h00] = itype(3'b100, 2'd0, 2'd0, 8'h05);
    rom[8'h05] = itype(3'b101, 2'd0, 2'd0, 8'h09);
    rom[8'h09] = li(2'd1, 8'h01);
    rom[8'h0A] = itype(3'b101, 2'd1, 2'd0, 8'h00);
    rom[8'h0B] = st(2'd1, 2'd0, 8'h40);
    run_prog(19, 8'h0C, "branch");
    chk("branch_ram40", ram8[8'h40], 8'h01);

    // PC wrap from 0xFF to 0x00.
    begin_test();
    rom[8'h00] = itype(3'b101, 2'd2, 2'd0, 8'hFE);
    rom[8'hFE] = li(2'd2, 8'h01);
    rom[8'hFF] = itype(3'b001, 2'd3, 2'd3, 8'h01);
    rom[8'h01] = st(2'd3, 2'd0, 8'h42);
    run_prog(20, 8'h02, "pcwrap");
    chk("pcwrap_ram42", ram8[8'h42], 8'h01);
    chk("pcwrap_ram16_42", ram16[8'h42], 16'h0001);

    // I/O read with 3 wait cycles, I/O write with 2 wait cycles.
    begin_test();
    rom[0] = itype(3'b010, 2'd1, 2'd0, 8'hFF);
    rom[1] = st(2'd1, 2'd0, 8'h50);
    rom[2] = li(2'd2, 8'h3C);
    rom[3] = st(2'd2, 2'd0, 8'hFF);
    ram_set(8'hFF, 8'h99, 16'h9999);
    we0 = we_total; rd0 = rd_rdy_total; wa0 = wr_acc_cnt; wu0 = wr_unstable;
    run_prog(23, 8'h04, "io");
    chk("io_rd_ram8", ram8[8'h50], 8'hF0);
    chk("io_rd_ram16", ram16[8'h50], 16'h00F0);
    chk("io_rd_ready_cycles", rd_rdy_total - rd0, 4);
    chk("io_wr_accepts", wr_acc_cnt - wa0, 1);
    chk("io_wr_acc_data", wr_acc_data, 8'h3C);
    chk("io_wr_stable", wr_unstable - wu0, 0);
    chk("io_wr_data_hold8", io_wr_data8, 8'h3C);
    chk("io_wr_data_hold16", io_wr_data16, 16'h003C);
    chk("io_wr_valid_low", io_wr_valid8, 1'b0);
    chk("io_we_only_ram", we_total - we0, 1);
    chk("io_ramFF8", ram8[8'hFF], 8'h99);
    chk("io_ramFF16", ram16[8'hFF], 16'h9999);

    // Reset while stalled in an I/O write.
    begin_test();
    wr_block = 1'b1;
    rom[0] = li(2'd1, 8'h11);
    rom[1] = st(2'd1, 2'd0, 8'hFF);
    ram_set(8'hFF, 8'h99, 16'h9999);
    we0 = we_total;
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge clk); #1;
      if (io_wr_valid8) seen = 1'b1;
    end
    chk("rstwr_valid_seen", seen, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rstwr_valid_held", io_wr_valid8, 1'b1);
    chk("rstwr_data_held", io_wr_data8, 8'h11);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rstwr_valid_drop", io_wr_valid8, 1'b0);
    chk("rstwr_pc", pc8, 8'h00);
    chk("rstwr_halted", halted8, 1'b0);
    chk("rstwr_data_clr", io_wr_data8, 8'h00);
    chk("rstwr_no_we", we_total - we0, 0);
    chk("rstwr_ramFF", ram8[8'hFF], 8'h99);
    wr_block = 1'b0;

    chk("lockstep_8_16", lock_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
